bcd_to_bin_seq: RTL and testbench

- Sequential converter from packed BCD digits to an N-bit unsigned binary value.
- Performs the inverse of the binary-to-7-segment/BCD display path.
- Sits behind the decimal-entry logic (switches/keypad digit registers), so a user-entered decimal number can drive the rest of the datapath as binary.
- Processes one digit per clock, MSD first: acc = acc*10 + digit.
- Flags non-BCD digits and results that exceed 2^N-1.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_mac10.sv | 32 +++
 rtl/bcd_to_bin_seq.sv | 98 +++++++++
 tb/tb_bcd_to_bin_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// the largest legal BCD digit and the controller state encoding.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // 2'd3 is unused and falls back to IDLE in the controller.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_mac10.sv
// One decimal step of the conversion: acc*10 + d with non-BCD digit
// detection and sticky saturation at 2^N-1.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [N-1:0] acc,
  input  logic [3:0]   d,
  input  logic         sat_in,
  output logic [N-1:0] acc_next,
  output logic         ovf_out,
  output logic         inv_out
);

  localparam logic [N+3:0] MAXVAL = {4'b0000, {N{1'b1}}};

  logic [3:0]   d_eff;
  logic [N+3:0] ext;
  logic [N+3:0] sum;

  // Four extra bits hold 1023*10+9, so the sum itself can never wrap.
  always_comb begin
    inv_out  = (d > BCD_MAX);
    d_eff    = inv_out ? 4'd0 : d;
    ext      = {4'b0000, acc};
    sum      = (ext << 3) + (ext << 1) + {{N{1'b0}}, d_eff};
    ovf_out  = sat_in || (sum > MAXVAL);
    acc_next = ovf_out ? {N{1'b1}} : sum[N-1:0];
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Converts packed BCD (MSD in the top nibble) to unsigned binary, one
// digit per clock, flagging non-BCD digits and results above 2^N-1.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int N      = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0]          bin_out,
  output logic                  ovf,
  output logic                  inv
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              state;
  logic [4*DIGITS-1:0] sr;
  logic [N-1:0]        acc;
  logic [CW-1:0]       cnt;
  logic                ovf_t;
  logic                inv_t;

  logic [N-1:0]        acc_next;
  logic                mac_ovf;
  logic                mac_inv;

  bcd_mac10 #(.N(N)) u_mac (
    .acc      (acc),
    .d        (sr[4*DIGITS-1 -: 4]),
    .sat_in   (ovf_t),
    .acc_next (acc_next),
    .ovf_out  (mac_ovf),
    .inv_out  (mac_inv)
  );

  // Results are registered as the DONE state is left, so done/bin_out
  // appear one cycle after the last digit and busy covers DIGITS+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      ovf     <= 1'b0;
      inv     <= 1'b0;
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      ovf_t   <= 1'b0;
      inv_t   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= bcd_in;
            acc   <= '0;
            cnt   <= CW'(DIGITS - 1);
            ovf_t <= 1'b0;
            inv_t <= 1'b0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          acc   <= acc_next;
          ovf_t <= mac_ovf;
          inv_t <= inv_t | mac_inv;
          sr    <= sr << 4;
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          bin_out <= inv_t ? '0 : acc;
          ovf     <= ovf_t;
          inv     <= inv_t;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed scenarios plus random
// BCD words compared against a digit-by-digit arithmetic reference.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        ovf;
  logic        inv;

  int checks = 0;
  int errors = 0;

  bcd_to_bin_seq #(.N(10), .DIGITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .ovf     (ovf),
    .inv     (inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal value with non-BCD digits counted as 0; saturates at 1023.
  function automatic void model(input logic [15:0] v, output int bin,
                                output bit m_ovf, output bit m_inv);
    int val;
    int d;
    val   = 0;
    m_inv = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) begin
        m_inv = 1'b1;
        d = 0;
      end
      val = val * 10 + d;
    end
    m_ovf = (val > 1023);
    bin   = m_inv ? 0 : (m_ovf ? 1023 : val);
  endfunction

  // Pulses start for one edge, then scrambles bcd_in to prove it is not re-read.
  task automatic start_conv(input logic [15:0] v);
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 16'($urandom);
  endtask

  // Counts negedges until done, bounded by a cycle budget.
  task automatic wait_done(output int cycles, output int busy_cycles,
                           output logic [9:0] first_bin);
    cycles      = 0;
    busy_cycles = 0;
    first_bin   = 'x;
    while (cycles < 50) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) first_bin = bin_out;
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    start  = 1'b0;
    bcd_in = 16'h0000;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bin_out, ovf, inv} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b bin=%0d ovf=%b inv=%b, want all 0",
               busy, done, bin_out, ovf, inv);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    logic [9:0] fb;
    start_conv(16'h0123);
    wait_done(cyc, bcyc, fb);
    checks++;
    if (cyc != 6 || bcyc != 5) begin
      errors++;
      $display("[TB] FAIL basic_latency: got done at cycle %0d busy %0d, want 6 and 5", cyc, bcyc);
    end
    checks++;
    if (bin_out !== 10'd123 || ovf !== 1'b0 || inv !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_value: got bin=%0d ovf=%b inv=%b, want 123 0 0", bin_out, ovf, inv);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || bin_out !== 10'd123) begin
      errors++;
      $display("[TB] FAIL basic_hold: got done=%b bin=%0d, want 0 123", done, bin_out);
    end
  endtask

  task automatic run_table(input string name, input logic [15:0] vals[]);
    int cyc, bcyc, eb;
    bit eo, ei;
    logic [9:0] fb;
    foreach (vals[i]) begin
      model(vals[i], eb, eo, ei);
      start_conv(vals[i]);
      wait_done(cyc, bcyc, fb);
      checks++;
      if (cyc != 6 || bin_out !== 10'(eb) || ovf !== eo || inv !== ei) begin
        errors++;
        $display("[TB] FAIL %s_%04h: got cyc=%0d bin=%0d ovf=%b inv=%b, want cyc=6 bin=%0d ovf=%b inv=%b",
                 name, vals[i], cyc, bin_out, ovf, inv, eb, eo, ei);
      end
    end
  endtask

  task automatic test_boundary();
    logic [15:0] v[] = '{16'h1023, 16'h1024, 16'h9999};
    run_table("boundary", v);
  endtask

  task automatic test_invalid();
    logic [15:0] v[] = '{16'h12A4, 16'h0000, 16'hF999, 16'h1A00};
    run_table("invalid", v);
  endtask

  task automatic test_random();
    int cyc, bcyc, eb, prev;
    bit eo, ei;
    logic [9:0] fb;
    logic [15:0] v;
    prev = int'(bin_out);
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 4; k++) begin
        v[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      end
      if (n % 3 == 0) v[15:12] = 4'($urandom_range(0, 1));
      model(v, eb, eo, ei);
      start_conv(v);
      wait_done(cyc, bcyc, fb);
      checks++;
      if (cyc != 6 || fb !== 10'(prev) || bin_out !== 10'(eb) || ovf !== eo || inv !== ei) begin
        errors++;
        $display("[TB] FAIL random_%04h: got cyc=%0d held=%0d bin=%0d ovf=%b inv=%b, want cyc=6 held=%0d bin=%0d ovf=%b inv=%b",
                 v, cyc, fb, bin_out, ovf, inv, prev, eb, eo, ei);
      end
      prev = eb;
    end
  endtask

  task automatic test_start_during_busy();
    int dones;
    logic [9:0] seen;
    start_conv(16'h0042);
    @(negedge clk);
    bcd_in = 16'h0777;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    seen  = '0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        seen = bin_out;
      end
    end
    checks++;
    if (dones != 1 || seen !== 10'd42) begin
      errors++;
      $display("[TB] FAIL start_during_busy: got %0d dones bin=%0d, want 1 done bin=42", dones, seen);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc;
    logic [9:0] fb;
    start_conv(16'h0500);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got busy=%b done=%b bin=%0d, want 0 0 0", busy, done, bin_out);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid_no_done: got done=%b, want 0", done);
      end
    end
    start_conv(16'h0007);
    wait_done(cyc, bcyc, fb);
    checks++;
    if (cyc != 6 || bin_out !== 10'd7 || ovf !== 1'b0 || inv !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset_conv: got cyc=%0d bin=%0d ovf=%b inv=%b, want 6 7 0 0",
               cyc, bin_out, ovf, inv);
    end
  endtask

  task automatic test_back_to_back();
    int idx[$];
    int bad_val;
    @(negedge clk);
    bcd_in = 16'h0001;
    start  = 1'b1;
    bad_val = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        idx.push_back(c);
        if (bin_out !== 10'd1) bad_val++;
      end
    end
    start = 1'b0;
    checks++;
    if (idx.size() != 5 || bad_val != 0) begin
      errors++;
      $display("[TB] FAIL back_to_back_count: got %0d dones (%0d wrong values), want 5 with bin=1",
               idx.size(), bad_val);
    end
    for (int i = 0; i < idx.size(); i++) begin
      checks++;
      if (idx[i] != 6 * (i + 1)) begin
        errors++;
        $display("[TB] FAIL back_to_back_spacing_%0d: got cycle %0d, want %0d", i, idx[i], 6 * (i + 1));
      end
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_invalid();
    test_random();
    test_start_during_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
